// File: rtl/tx_iq_buffer.sv
// -----------------------------------------------------------------------------
// tx_iq_buffer
//
// TX sample buffer feeding the transmitter's interpolator chain. Host words
// arrive 16 bits at a time (I first, then Q) and are packed into 32-bit {I,Q}
// entries held in a block-RAM FIFO. The head entry is kept in a registered
// output stage (tsiq_data) and the consumer takes it with tsiq_read_strobe.
//
// A prime/run state machine holds off the consumer until PRIME entries have
// accumulated, and drops back to priming after an underflow. Playback
// therefore restarts with a full cushion instead of stuttering one sample
// at a time.
//
// Ports
//   clk              system clock, everything on the rising edge
//   reset            synchronous, active-high; like flush, and also clears flags
//   wr_data          host sample word (signed 16-bit)
//   wr_strobe        wr_data valid this cycle
//   wr_sync          force the pair phase to I (frame boundary)
//   flush            discard all buffered samples (flags are kept)
//   tsiq_read_strobe consumer takes tsiq_data on this edge
//   tsiq_data        {I[31:16], Q[15:0]} head sample, registered
//   fill_level       entries in RAM (the output register is not counted)
//   almost_full      free entries <= AF_MARGIN, one cycle behind fill_level
//   overflow         sticky: a pair was dropped because the RAM was full
//   underflow        sticky: strobe in RUN with no valid sample
//   flag_clr         clears overflow/underflow (a same-cycle set wins)
//   running          high in RUN
// -----------------------------------------------------------------------------
module tx_iq_buffer #(
    parameter int AW        = 10,
    parameter int PRIME     = 512,
    parameter int AF_MARGIN = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   wr_data,
    input  logic          wr_strobe,
    input  logic          wr_sync,
    input  logic          flush,
    input  logic          tsiq_read_strobe,
    output logic [31:0]   tsiq_data,
    output logic [AW:0]   fill_level,
    output logic          almost_full,
    output logic          overflow,
    output logic          underflow,
    input  logic          flag_clr,
    output logic          running
);

    localparam int DEPTH = 1 << AW;

    // Level thresholds expressed at fill_level width.
    localparam logic [AW:0] FULL_LVL  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME);
    localparam logic [AW:0] AF_LVL    = (AW+1)'(DEPTH - AF_MARGIN);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Pair phase: 0 = next word is I, 1 = next word is Q.
    localparam logic PH_I = 1'b0;
    localparam logic PH_Q = 1'b1;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   fill_level_q;
    logic [AW:0]   fill_level_d;
    logic          phase_q;
    logic          phase_d;
    logic [15:0]   hold_q;
    logic [15:0]   hold_d;

    state_t        state_q;
    state_t        state_d;
    logic          out_valid_q;
    logic          out_valid_d;
    logic [31:0]   tsiq_data_q;
    logic          running_q;
    logic          almost_full_q;
    logic          overflow_q;
    logic          underflow_q;

    // Per-cycle control
    logic          push_req;    // packer completed a pair this cycle
    logic          push_en;     // pair actually written to RAM
    logic          pop_en;      // head entry moved into the output register
    logic          clear_data;  // output register returns to zero
    logic          ovf_set;
    logic          unf_set;
    logic          ram_full;
    logic          ram_empty;

    assign ram_full  = (fill_level_q == FULL_LVL);
    assign ram_empty = (fill_level_q == '0);

    // ------------------------------------------------------------------
    // Word packer. A wr_sync together with a strobe makes that word the new
    // I; wr_sync alone just resets the phase, which abandons any held I.
    // ------------------------------------------------------------------
    always_comb begin
        phase_d  = phase_q;
        hold_d   = hold_q;
        push_req = 1'b0;
        if (wr_strobe) begin
            if (wr_sync || (phase_q == PH_I)) begin
                hold_d  = wr_data;
                phase_d = PH_Q;
            end else begin
                push_req = 1'b1;
                phase_d  = PH_I;
            end
        end else if (wr_sync) begin
            phase_d = PH_I;
        end
    end

    // A completed pair is dropped when the RAM is full; the phase still
    // advances so the next word is treated as a fresh I.
    assign push_en = push_req && !ram_full && !flush;
    assign ovf_set = push_req &&  ram_full && !flush;

    // ------------------------------------------------------------------
    // Prime/run control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        pop_en      = 1'b0;
        clear_data  = 1'b0;
        unf_set     = 1'b0;

        unique case (state_q)
            ST_WAIT: begin
                // Strobes are ignored while priming.
                if (fill_level_q >= PRIME_LVL) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // RAM cannot be empty here unless PRIME is 0; guard anyway.
                if (!ram_empty) begin
                    pop_en      = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                    clear_data  = 1'b1;
                end
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tsiq_read_strobe && !out_valid_q) begin
                    // Consumer found nothing: record it and re-prime.
                    unf_set     = 1'b1;
                    out_valid_d = 1'b0;
                    clear_data  = 1'b1;
                    state_d     = ST_WAIT;
                end else if (tsiq_read_strobe || !out_valid_q) begin
                    // Either the head was just consumed, or the output stage
                    // is empty and waiting for data: refill when possible.
                    if (!ram_empty) begin
                        pop_en      = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        clear_data  = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_WAIT;
                out_valid_d = 1'b0;
                clear_data  = 1'b1;
            end
        endcase

        // Flush overrides everything that happens on the read side.
        if (flush) begin
            state_d     = ST_WAIT;
            out_valid_d = 1'b0;
            pop_en      = 1'b0;
            clear_data  = 1'b1;
            unf_set     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // RAM level. A push and a pop in the same cycle cancel out.
    // ------------------------------------------------------------------
    always_comb begin
        fill_level_d = fill_level_q;
        if (flush) begin
            fill_level_d = '0;
        end else begin
            unique case ({push_en, pop_en})
                2'b10:   fill_level_d = fill_level_q + 1'b1;
                2'b01:   fill_level_d = fill_level_q - 1'b1;
                default: fill_level_d = fill_level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample RAM write port (no reset so it maps onto block RAM).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= {hold_q, wr_data};
        end
    end

    // ------------------------------------------------------------------
    // Registered state, pointers, output stage and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_WAIT;
            out_valid_q   <= 1'b0;
            running_q     <= 1'b0;
            tsiq_data_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_level_q  <= '0;
            phase_q       <= PH_I;
            hold_q        <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            running_q    <= (state_d == ST_RUN);
            fill_level_q <= fill_level_d;

            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                phase_q  <= PH_I;
            end else begin
                if (push_en) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop_en) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                phase_q <= phase_d;
                hold_q  <= hold_d;
            end

            // The RAM read register doubles as the output stage; the
            // entry at rd_ptr_q was written at least one edge earlier.
            if (pop_en) begin
                tsiq_data_q <= mem_q[rd_ptr_q];
            end else if (clear_data) begin
                tsiq_data_q <= '0;
            end

            // Deliberately a cycle behind fill_level.
            almost_full_q <= (fill_level_q >= AF_LVL);

            // Sticky flags: a set in the same cycle as flag_clr wins.
            overflow_q  <= ovf_set | (overflow_q  & ~flag_clr);
            underflow_q <= unf_set | (underflow_q & ~flag_clr);
        end
    end

    assign tsiq_data   = tsiq_data_q;
    assign fill_level  = fill_level_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign running     = running_q;

endmodule

// File: tb/tb_tx_iq_buffer.sv
// -----------------------------------------------------------------------------
// tb_tx_iq_buffer
//
// Scoreboard bench for tx_iq_buffer. The stimulus side keeps a behavioural
// model of the buffer as a queue of every accepted {I,Q} sample that the
// consumer has not yet taken; samples are pushed onto it as pairs are
// written. A separate monitor pops and compares on every consumer strobe.
// Status outputs are compared against levels derived from that queue.
// -----------------------------------------------------------------------------
module tb_tx_iq_buffer;

    localparam int AW        = 10;
    localparam int PRIME     = 512;
    localparam int AF_MARGIN = 64;
    localparam int DEPTH     = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   wr_data = '0;
    logic          wr_strobe = 1'b0;
    logic          wr_sync = 1'b0;
    logic          flush = 1'b0;
    logic          tsiq_read_strobe = 1'b0;
    logic [31:0]   tsiq_data;
    logic [AW:0]   fill_level;
    logic          almost_full;
    logic          overflow;
    logic          underflow;
    logic          flag_clr = 1'b0;
    logic          running;

    always #5 clk = ~clk;

    tx_iq_buffer #(
        .AW        (AW),
        .PRIME     (PRIME),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_data          (wr_data),
        .wr_strobe        (wr_strobe),
        .wr_sync          (wr_sync),
        .flush            (flush),
        .tsiq_read_strobe (tsiq_read_strobe),
        .tsiq_data        (tsiq_data),
        .fill_level       (fill_level),
        .almost_full      (almost_full),
        .overflow         (overflow),
        .underflow        (underflow),
        .flag_clr         (flag_clr),
        .running          (running)
    );

    // ------------------------------------------------------------------
    // Counters and reference model
    // ------------------------------------------------------------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          sample_no = 0;

    logic [31:0] exp_q[$];   // accepted, not yet consumed samples
    logic [15:0] pend_q[$];  // held I word waiting for its Q (0 or 1 entries)
    bit          model_run = 1'b0;
    bit          model_ovf = 1'b0;
    bit          model_unf = 1'b0;
    bit          strobe_valid = 1'b0;  // current strobe should yield a sample

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Entries in RAM: everything not consumed, minus the one sitting in the
    // output register while running.
    function automatic int level();
        return exp_q.size() - ((model_run && exp_q.size() > 0) ? 1 : 0);
    endfunction

    function automatic void accept_pair(logic [31:0] p);
        if (level() == DEPTH) begin
            model_ovf = 1'b1;
        end else begin
            exp_q.push_back(p);
            if (!model_run && level() >= PRIME) model_run = 1'b1;
        end
    endfunction

    function automatic void model_word(logic [15:0] w, bit sync);
        if (sync || pend_q.size() == 0) begin
            pend_q.delete();
            pend_q.push_back(w);
        end else begin
            accept_pair({pend_q[0], w});
            pend_q.delete();
        end
    endfunction

    function automatic void decide_strobe();
        if (!model_run) begin
            strobe_valid = 1'b0;
        end else if (exp_q.size() == 0) begin
            strobe_valid = 1'b0;
            model_unf    = 1'b1;
            model_run    = 1'b0;
        end else begin
            strobe_valid = 1'b1;
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        pend_q.delete();
        model_run = 1'b0;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] w, input bit sync);
        wr_data   = w;
        wr_strobe = 1'b1;
        wr_sync   = sync;
        model_word(w, sync);
        tick();
        wr_strobe = 1'b0;
        wr_sync   = 1'b0;
    endtask

    task automatic sync_pulse();
        wr_sync = 1'b1;
        pend_q.delete();
        tick();
        wr_sync = 1'b0;
    endtask

    task automatic strobe_task();
        decide_strobe();
        tsiq_read_strobe = 1'b1;
        tick();
        tsiq_read_strobe = 1'b0;
        repeat (3) tick();
    endtask

    task automatic clear_flags();
        flag_clr  = 1'b1;
        model_ovf = 1'b0;
        model_unf = 1'b0;
        tick();
        flag_clr  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        tick();
        tick();
        check({tag, ".fill_level"},  32'(fill_level), 32'(level()));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(level() >= DEPTH - AF_MARGIN));
        check({tag, ".overflow"},    32'(overflow),    32'(model_ovf));
        check({tag, ".underflow"},   32'(underflow),   32'(model_unf));
        check({tag, ".running"},     32'(running),     32'(model_run));
    endtask

    // ------------------------------------------------------------------
    // Monitor: one line per consumed transaction
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (tsiq_read_strobe === 1'b1) begin
            if (strobe_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sample: strobe expected data but scoreboard empty (t=%0t)", $time);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("sample", tsiq_data, e);
                    $display("sample %0d: got %h expected %h", sample_no, tsiq_data, e);
                    sample_no++;
                end
            end else begin
                check("idle_data", tsiq_data, 32'h0);
                $display("idle strobe: got %h expected 00000000", tsiq_data);
            end
        end
    end

    // Watchdog: the sequence is fixed-length, this only guards against a hang.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] w;
        logic [15:0] a;
        int          r;
        int          guard;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("reset.tsiq_data", tsiq_data, 32'h0);
        check_status("reset");

        // Prime with I=n, Q=-n
        for (int n = 0; n < PRIME; n++) begin
            w = 16'(n);
            write_word(w, 1'b0);
            w = 16'(-n);
            write_word(w, 1'b0);
        end
        check("prime.level", 32'(fill_level), 32'(PRIME));
        check("prime.run_t0", 32'(running), 32'h0);
        tick();
        check("prime.run_t1", 32'(running), 32'h0);
        tick();
        check("prime.run_t2", 32'(running), 32'h1);
        check("prime.head", tsiq_data, 32'h0);
        check("prime.level_after_load", 32'(fill_level), 32'(PRIME - 1));

        // Consume all entries, one strobe every 4 cycles
        strobe_task();
        check("first_refill", tsiq_data, 32'h0001FFFF);
        for (int i = 1; i < PRIME; i++) strobe_task();
        check("drained.data", tsiq_data, 32'h0);
        check_status("drained");
        strobe_task();  // nothing valid: underflow and re-prime
        check_status("underflow");

        // Overflow: no reads, more pairs than fit
        clear_flags();
        check("flag_clr.underflow", 32'(underflow), 32'h0);
        for (int p = 0; p < DEPTH + 2; p++) begin
            w = 16'($urandom);
            write_word(w, 1'b0);
            w = 16'($urandom);
            write_word(w, 1'b0);
            if (level() == DEPTH - AF_MARGIN - 1 || level() == DEPTH - AF_MARGIN)
                check_status("af_edge");
            if (p == DEPTH)
                check("pre_drop.overflow", 32'(overflow), 32'h0);
        end
        check_status("overflow");

        // Simultaneous push and strobe at level 700
        while (level() > 700) strobe_task();
        check_status("level700");
        w = 16'($urandom);
        write_word(w, 1'b0);
        w = 16'($urandom);
        wr_data          = w;
        wr_strobe        = 1'b1;
        decide_strobe();
        tsiq_read_strobe = 1'b1;
        model_word(w, 1'b0);
        tick();
        wr_strobe        = 1'b0;
        tsiq_read_strobe = 1'b0;
        check("push_pop.level", 32'(fill_level), 32'd700);
        repeat (3) tick();

        // Flush in RUN at level 300
        while (level() > 300) strobe_task();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        check("flush.level", 32'(fill_level), 32'h0);
        check("flush.data", tsiq_data, 32'h0);
        check("flush.running", 32'(running), 32'h0);
        check("flush.overflow", 32'(overflow), 32'(model_ovf));
        check("flush.underflow", 32'(underflow), 32'(model_unf));
        check_status("post_flush");
        clear_flags();
        check("flag_clr.overflow", 32'(overflow), 32'h0);

        // Odd word count, wr_sync alone, then pairs; then wr_sync with a word
        for (int i = 0; i < 3; i++) begin
            w = 16'($urandom);
            write_word(w, 1'b0);
        end
        sync_pulse();
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            write_word(w, 1'b0);
        end
        a = 16'($urandom);
        write_word(a, 1'b0);
        w = 16'($urandom);
        write_word(w, 1'b1);
        w = 16'($urandom);
        write_word(w, 1'b0);

        // Random fill until primed, with occasional frame syncs
        guard = 0;
        while (!model_run && guard < 4000) begin
            r = $urandom_range(0, 19);
            if (r == 0) sync_pulse();
            else begin
                w = 16'($urandom);
                write_word(w, r == 1);
            end
            guard++;
        end
        check_status("random_prime");

        // Mixed random traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 3);
            if (r <= 1) begin
                w = 16'($urandom);
                write_word(w, $urandom_range(0, 15) == 0);
            end else if (r == 2 && level() > 2) begin
                strobe_task();
            end else begin
                tick();
            end
        end
        check_status("mixed");

        // Drain everything, then one strobe too many
        guard = 0;
        while (exp_q.size() > 0 && guard < 2 * DEPTH) begin
            strobe_task();
            guard++;
        end
        check("final_drain.data", tsiq_data, 32'h0);
        strobe_task();
        check_status("final_underflow");

        // Reset in the middle of running clears data, level and flags
        for (int p = 0; p < PRIME + 20; p++) begin
            w = 16'($urandom);
            write_word(w, 1'b0);
            w = 16'($urandom);
            write_word(w, 1'b0);
        end
        check_status("pre_reset");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        check("mid_reset.data", tsiq_data, 32'h0);
        check_status("mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
